// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//   Sequencer for the countdown timer datapath. Holds a DIGITS-wide BCD count,
//   loads it from PRESET (digits above 9 clamp to 9), and runs a
//   IDLE/RUN/PAUSE/DONE control FSM driven by START/STOP/LOAD pulses.
//   The count decrements once per TICK while running. On expiry DONE pulses
//   and ALARM is held for ALARM_TICKS ticks before returning to IDLE.
//
//   Optional feature macro: CDT_AUTO_RELOAD_EN
//     When defined, expiry reloads the clamped PRESET and keeps running.
//     ALARM then pulses together with DONE, and the DONE state is never entered.
//     A zero PRESET at expiry drops back to IDLE instead.
//
// Ports
//   CLK     in   1          system clock, rising edge
//   CLR     in   1          asynchronous active-high reset
//   CE      in   1          clock enable; low freezes all state
//   TICK    in   1          one-cycle pulse per second
//   START   in   1          run / resume pulse
//   STOP    in   1          pause (RUN) or abort to IDLE (other states)
//   LOAD    in   1          copy PRESET into the count
//   PRESET  in   4*DIGITS   BCD preset, digit 0 in [3:0]
//   Q       out  4*DIGITS   current BCD count (registered)
//   RUN     out  1          high while in RUN
//   ALARM   out  1          high while in DONE (auto-reload: pulse with DONE)
//   DONE    out  1          one-cycle pulse when the count reaches zero
// -----------------------------------------------------------------------------
module countdown_ctrl #(
  parameter int DIGITS      = 4,
  parameter int ALARM_TICKS = 5
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic                  TICK,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   PRESET,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  RUN,
  output logic                  ALARM,
  output logic                  DONE
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      alarm_cnt_reg, alarm_cnt_next;
  logic [W-1:0]    q_next;
  logic [W-1:0]    preset_clamped;
  logic [W-1:0]    q_dec;
  logic [DIGITS:0] borrow;
  logic            q_zero;
  logic            q_one;
  logic            done_next;
  logic            alarm_next;

  // Per-digit clamp of the preset and a rippling BCD decrement of the count.
  // borrow[0] is the "-1" injected at digit 0; a borrow that survives every
  // digit means the count is all zeros.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] q_digit;
      logic [3:0] p_digit;

      assign q_digit = Q[4*gi +: 4];
      assign p_digit = PRESET[4*gi +: 4];

      assign preset_clamped[4*gi +: 4] = (p_digit > 4'd9) ? 4'd9 : p_digit;

      assign q_dec[4*gi +: 4] = !borrow[gi]      ? q_digit :
                                (q_digit == 4'd0) ? 4'd9    :
                                                    q_digit - 4'd1;
      assign borrow[gi+1] = borrow[gi] & (q_digit == 4'd0);
    end
  endgenerate

  assign q_zero = borrow[DIGITS];
  assign q_one  = (Q == W'(1));

  always_comb begin
    state_next     = state_reg;
    q_next         = Q;
    alarm_cnt_next = alarm_cnt_reg;
    done_next      = 1'b0;

    if (CE) begin
      unique case (state_reg)
        S_IDLE: begin
          // STOP outranks everything and there is nowhere to abort to.
          if (!STOP) begin
            if (LOAD)
              q_next = preset_clamped;
            else if (START && !q_zero)
              state_next = S_RUN;
          end
        end

        S_RUN: begin
          // STOP wins over a simultaneous TICK, so that tick is lost.
          // LOAD and START have no meaning here.
          if (STOP) begin
            state_next = S_PAUSE;
          end else if (TICK) begin
            if (q_one) begin
              done_next = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
              if (preset_clamped == '0) begin
                q_next     = '0;
                state_next = S_IDLE;
              end else begin
                q_next = preset_clamped;
              end
`else
              q_next         = '0;
              state_next     = S_DONE;
              alarm_cnt_next = 4'd0;
`endif
            end else if (!q_zero) begin
              q_next = q_dec;
            end
          end
        end

        S_PAUSE: begin
          // A zero count (after loading a zero preset) cannot be resumed,
          // which keeps RUN from ever sitting on 0000.
          if (STOP)
            state_next = S_IDLE;
          else if (LOAD)
            q_next = preset_clamped;
          else if (START && !q_zero)
            state_next = S_RUN;
        end

        S_DONE: begin
          if (STOP) begin
            state_next = S_IDLE;
          end else if (LOAD) begin
            q_next     = preset_clamped;
            state_next = S_IDLE;
          end else if (TICK) begin
            alarm_cnt_next = alarm_cnt_reg + 4'd1;
            if (alarm_cnt_reg == 4'(ALARM_TICKS - 1))
              state_next = S_IDLE;
          end
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

`ifdef CDT_AUTO_RELOAD_EN
  assign alarm_next = done_next;
`else
  assign alarm_next = (state_next == S_DONE);
`endif

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state itself.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_reg     <= S_IDLE;
      alarm_cnt_reg <= 4'd0;
      Q             <= '0;
      RUN           <= 1'b0;
      ALARM         <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      alarm_cnt_reg <= alarm_cnt_next;
      Q             <= q_next;
      RUN           <= (state_next == S_RUN);
      ALARM         <= alarm_next;
      DONE          <= done_next;
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
//   Directed scenarios followed by a randomized run, all checked every cycle
//   against a decimal-integer model of the countdown controller.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        CE;
  logic        TICK;
  logic        START;
  logic        STOP;
  logic        LOAD;
  logic [15:0] PRESET;
  logic [15:0] Q;
  logic        RUN;
  logic        ALARM;
  logic        DONE;

  countdown_ctrl #(.DIGITS(4), .ALARM_TICKS(5)) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .CE     (CE),
    .TICK   (TICK),
    .START  (START),
    .STOP   (STOP),
    .LOAD   (LOAD),
    .PRESET (PRESET),
    .Q      (Q),
    .RUN    (RUN),
    .ALARM  (ALARM),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: count held as a plain decimal integer.
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;
  localparam int M_ALARM_TICKS = 5;

  int m_mode;
  int m_q;
  int m_ticks;
  bit m_done;

`ifdef CDT_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  function automatic int clamp_val(input logic [15:0] p);
    int v = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_q     = 0;
    m_ticks = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (CE) begin
      case (m_mode)
        M_IDLE: begin
          if (STOP) begin
          end else if (LOAD) m_q = clamp_val(PRESET);
          else if (START && m_q != 0) m_mode = M_RUN;
        end
        M_RUN: begin
          if (STOP) m_mode = M_PAUSE;
          else if (TICK) begin
            if (m_q == 1) begin
              m_done = 1'b1;
              if (AUTO) begin
                m_q = clamp_val(PRESET);
                if (m_q == 0) m_mode = M_IDLE;
              end else begin
                m_q     = 0;
                m_mode  = M_DONE;
                m_ticks = 0;
              end
            end else if (m_q > 0) begin
              m_q = m_q - 1;
            end
          end
        end
        M_PAUSE: begin
          if (STOP) m_mode = M_IDLE;
          else if (LOAD) m_q = clamp_val(PRESET);
          else if (START && m_q != 0) m_mode = M_RUN;
        end
        default: begin
          if (STOP) m_mode = M_IDLE;
          else if (LOAD) begin
            m_q    = clamp_val(PRESET);
            m_mode = M_IDLE;
          end else if (TICK) begin
            m_ticks++;
            if (m_ticks == M_ALARM_TICKS) m_mode = M_IDLE;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic exp_alarm;
    exp_alarm = AUTO ? m_done : (m_mode == M_DONE);
    check({tag, "_q"},     Q,             to_bcd(m_q));
    check({tag, "_run"},   16'(RUN),      16'(m_mode == M_RUN));
    check({tag, "_alarm"}, 16'(ALARM),    16'(exp_alarm));
    check({tag, "_done"},  16'(DONE),     16'(m_done));
  endtask

  // One clock cycle with the given pulses; inputs return to idle afterwards.
  task automatic cyc(input string tag, input logic ce, input logic tick,
                     input logic start, input logic stop, input logic load);
    CE = ce; TICK = tick; START = start; STOP = stop; LOAD = load;
    @(posedge CLK);
    model_step();
    #1;
    $display("cyc %-10s ce=%b tick=%b start=%b stop=%b load=%b preset=%h -> Q=%h RUN=%b ALARM=%b DONE=%b",
             tag, ce, tick, start, stop, load, PRESET, Q, RUN, ALARM, DONE);
    check_model(tag);
    CE = 1'b1; TICK = 1'b0; START = 1'b0; STOP = 1'b0; LOAD = 1'b0;
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    CLR = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; CE = 1'b1; TICK = 1'b0; START = 1'b0; STOP = 1'b0; LOAD = 1'b0;
    PRESET = 16'h0000;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b0;
    check_model("rst");

    // 1: asynchronous clear in the middle of a run
    PRESET = 16'h0042;
    cyc("t1_load", 1, 0, 0, 0, 1);
    cyc("t1_start", 1, 0, 1, 0, 0);
    cyc("t1_tick", 1, 1, 0, 0, 0);
    check("t1_pre_clr_q", Q, 16'h0041);
    #2;
    CLR = 1'b1;
    model_reset();
    #1;
    check_model("t1_async");
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    check("t1_q0", Q, 16'h0000);
    cyc("t1_after", 1, 1, 0, 0, 0);

`ifndef CDT_AUTO_RELOAD_EN
    // 2: full countdown from 12 and the alarm sequence
    PRESET = 16'h0012;
    cyc("t2_load", 1, 0, 0, 0, 1);
    cyc("t2_start", 1, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc($sformatf("t2_tk%0d", i), 1, 1, 0, 0, 0);
      if (i == 9) check("t2_q_0003", Q, 16'h0003);
      if (i == 3) check("t2_q_0009", Q, 16'h0009);
    end
    check("t2_done", 16'(DONE), 16'h1);
    check("t2_alarm", 16'(ALARM), 16'h1);
    for (int i = 1; i <= 5; i++) begin
      cyc($sformatf("t2_al%0d", i), 1, 1, 0, 0, 0);
      if (i == 4) check("t2_alarm4", 16'(ALARM), 16'h1);
    end
    check("t2_alarm_off", 16'(ALARM), 16'h0);
    check("t2_run_off", 16'(RUN), 16'h0);
`endif

    // 3: borrow across three digits, then preset clamping
    PRESET = 16'h1000;
    cyc("t3_load", 1, 0, 0, 0, 1);
    cyc("t3_start", 1, 0, 1, 0, 0);
    cyc("t3_tick", 1, 1, 0, 0, 0);
    check("t3_q_0999", Q, 16'h0999);
    cyc("t3_stop", 1, 0, 0, 1, 0);
    PRESET = 16'h9A9F;
    cyc("t3_ld9a9f", 1, 0, 0, 0, 1);
    check("t3_q_9999", Q, 16'h9999);
    cyc("t3_abort", 1, 0, 0, 1, 0);

    // 4: STOP beats TICK, resume, then pause and abort
    PRESET = 16'h0005;
    cyc("t4_load", 1, 0, 0, 0, 1);
    cyc("t4_start", 1, 0, 1, 0, 0);
    cyc("t4_stptk", 1, 1, 0, 1, 0);
    check("t4_q_hold", Q, 16'h0005);
    check("t4_paused", 16'(RUN), 16'h0);
    cyc("t4_resume", 1, 0, 1, 0, 0);
    check("t4_running", 16'(RUN), 16'h1);
    cyc("t4_stop1", 1, 0, 0, 1, 0);
    cyc("t4_stop2", 1, 0, 0, 1, 0);
    check("t4_idle_q", Q, 16'h0005);

    // 5: START on zero ignored, CE low freezes everything
    do_reset();
    cyc("t5_start0", 1, 0, 1, 0, 0);
    check("t5_run0", 16'(RUN), 16'h0);
    PRESET = 16'h0003;
    cyc("t5_load", 1, 0, 0, 0, 1);
    cyc("t5_start", 1, 0, 1, 0, 0);
    cyc("t5_ce_tk", 0, 1, 0, 0, 0);
    cyc("t5_ce_st", 0, 0, 0, 1, 0);
    check("t5_ce_q", Q, 16'h0003);
    cyc("t5_stop", 1, 0, 0, 1, 0);
    cyc("t5_abort", 1, 0, 0, 1, 0);

`ifdef CDT_AUTO_RELOAD_EN
    // 6: auto-reload keeps running and pulses DONE every third tick
    PRESET = 16'h0003;
    cyc("t6_load", 1, 0, 0, 0, 1);
    cyc("t6_start", 1, 0, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc($sformatf("t6_tk%0d", i), 1, 1, 0, 0, 0);
      check($sformatf("t6_run%0d", i), 16'(RUN), 16'h1);
      check($sformatf("t6_done%0d", i), 16'(DONE), 16'((i % 3) == 0));
    end
    check("t6_q_3", Q, 16'h0003);
    cyc("t6_stop", 1, 0, 0, 1, 0);
    cyc("t6_abort", 1, 0, 0, 1, 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int ctl;
      logic ce_r, tk_r;
      ce_r = ($urandom % 8) != 0;
      tk_r = ($urandom % 3) == 0;
      ctl  = int'($urandom % 12);
      if (($urandom % 4) == 0) PRESET = 16'($urandom);
      else PRESET = to_bcd(int'($urandom % 25));
      cyc($sformatf("rnd%0d", n), ce_r, tk_r, ctl == 0 || ctl == 1, ctl == 2, ctl == 3);
      if (($urandom % 300) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
